aes_encipher_block_p: RTL
=========================

Name: aes_encipher_block_p

Overview:
Parametrised AES encipher datapath and control. It runs the initial, main and final rounds for AES-128, AES-192 and AES-256. It substitutes SBOX_WORDS 32-bit words per cycle through an external, shared combinational S-box. Round keys come from the key memory, indexed by the round output. The block sits between the AES core top-level control and the key memory / S-box.

Parameters:
SBOX_WORDS, 1, number of 32-bit words substituted per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error. S = 4/SBOX_WORDS cycles per SubBytes phase.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
next  input  1  start a block operation; accepted only in IDLE
abort  input  1  synchronous cancel of an operation in progress
keylen  input  2  key size: 0 = 128, 1 = 192, 2 = 256, 3 = reserved and treated as 128
round  output  4  current round index; key memory returns round_key for this index combinationally
round_key  input  128  round key for the current round
sboxw  output  32*SBOX_WORDS  words to substitute; lowest word index in the MSBs
new_sboxw  input  32*SBOX_WORDS  substituted words, same cycle, same ordering
block  input  128  plaintext; sampled only in INIT
new_block  output  128  state register; holds the ciphertext when ready = 1 after a completed run
ready  output  1  high when idle / result valid

Behaviour:
- Reset values:
  - ready = 1, round = 0, new_block = 0, sboxw = 0.
  - FSM = IDLE, word counter = 0, latched Nr = 10.
- Nr is latched when next is accepted:
  - 10 for keylen 0 or 3; 12 for keylen 1; 14 for keylen 2.
  - Changes to keylen mid-operation have no effect.
- FSM states: IDLE, INIT, SBOX, MAIN, FINAL.
- IDLE:
  - next = 1 and abort = 0 → ready <= 0, round <= 0, latch Nr, go to INIT.
  - next is ignored in every other state.
- INIT, one cycle:
  - state <= block ^ round_key (key 0).
  - round <= 1, word counter <= 0, go to SBOX.
- SBOX, S cycles:
  - sboxw = state words [w .. w+SBOX_WORDS-1].
  - Those words <= new_sboxw; w <= w + SBOX_WORDS (2-bit wrap).
  - On the last word group: go to MAIN if round < Nr, else go to FINAL.
- MAIN, one cycle:
  - state <= MixColumns(ShiftRows(state)) ^ round_key.
  - round <= round + 1, w <= 0, go to SBOX.
- FINAL, one cycle:
  - state <= ShiftRows(state) ^ round_key (key Nr).
  - ready <= 1, round unchanged (= Nr), go to IDLE.
- Sequence per block: INIT, then Nr SBOX phases interleaved with Nr-1 MAIN cycles, then FINAL.
- Latency: next sampled at edge t → ready = 1 and new_block valid at edge t + 1 + Nr*S + Nr.
  - SBOX_WORDS = 1: 51 / 61 / 71 cycles for Nr = 10 / 12 / 14.
  - SBOX_WORDS = 4: 21 / 25 / 29 cycles for Nr = 10 / 12 / 14.
- ShiftRows and MixColumns follow FIPS-197 exactly:
  - State is column-major; word 0 = bits [127:96] = column 0.
  - Row r is rotated left by r columns.
  - MixColumns coefficients are {2,3,1,1} over GF(2^8) with polynomial 0x11b.
- sboxw = 0 in all states other than SBOX.
- new_block is stable while in IDLE; only INIT, SBOX, MAIN and FINAL write it.
- abort = 1 in any non-IDLE state:
  - Next edge: FSM <= IDLE, ready <= 1, new_block <= 0, round <= 0, w <= 0.
  - abort in IDLE has no effect; abort together with next in IDLE → next ignored.
  - abort during FINAL wins: new_block is cleared, not updated.
- Asynchronous reset mid-operation returns all state to the reset values immediately. No partial result is retained.

Test Plan:
- AES-128 (FIPS-197 C.1), key 000102..0f, block 00112233445566778899aabbccddeeff, reference key schedule driven on round → new_block = 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises exactly 51 cycles after next (SBOX_WORDS = 1) and 21 cycles after next (SBOX_WORDS = 4).
- AES-192 (C.2), key 000102..17, same block → dda97ca4864cdfe06eaf70a0ec0d7191, latency 61 cycles (SBOX_WORDS = 1); round sequence observed 0, 1..12.
- AES-256 (C.3), key 000102..1f, same block → 8ea2b7ca516745bfeafc49904b496089 for SBOX_WORDS = 1, 2 and 4; latency 71 / 43 / 29 cycles.
- keylen switched from 2 to 0 at cycle 5 of an AES-256 run → result still the AES-256 vector; next pulsed mid-run → ignored, no restart.
- abort asserted at SBOX round 3 → one cycle later ready = 1, new_block = 0, round = 0; a following AES-128 run produces 69c4e0d8...c55a.
- reset_n pulsed low mid-MAIN → ready = 1, new_block = 0, sboxw = 0 immediately; keylen = 3 run → AES-128 result and 51-cycle latency.

Source files
------------

// File: rtl/aes_encipher_block_p.sv
// AES encipher round datapath and control for 128/192/256-bit keys.
// SubBytes is done through an external S-box, SBOX_WORDS 32-bit words per cycle.
module aes_encipher_block_p #(
  parameter int SBOX_WORDS = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      next,
  input  logic                      abort,
  input  logic [1:0]                keylen,
  output logic [3:0]                round,
  input  logic [127:0]              round_key,
  output logic [32*SBOX_WORDS-1:0]  sboxw,
  input  logic [32*SBOX_WORDS-1:0]  new_sboxw,
  input  logic [127:0]              block,
  output logic [127:0]              new_block,
  output logic                      ready
);

  if (SBOX_WORDS != 1 && SBOX_WORDS != 2 && SBOX_WORDS != 4) begin : g_bad_sbox_words
    $error("SBOX_WORDS must be 1, 2 or 4");
  end

  localparam int         GW     = 32 * SBOX_WORDS;
  localparam logic [1:0] WSTEP  = 2'(SBOX_WORDS);
  localparam logic [1:0] LAST_W = 2'(4 - SBOX_WORDS);

  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_SBOX, ST_MAIN, ST_FINAL} state_e;

  state_e       state_q, state_d;
  logic [127:0] block_q, block_d;
  logic [3:0]   round_q, round_d;
  logic [3:0]   nr_q, nr_d;
  logic [1:0]   w_q, w_d;
  logic         ready_q, ready_d;
  int           grp_hi;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (col c, row r) sits at bits [127-8*(4c+r) -: 8]; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      block_q <= '0;
      round_q <= '0;
      nr_q    <= 4'd10;
      w_q     <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      block_q <= block_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      w_q     <= w_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (next && !abort) state_d = ST_INIT;
      ST_INIT:  state_d = ST_SBOX;
      ST_SBOX:  if (w_q == LAST_W) state_d = (round_q < nr_q) ? ST_MAIN : ST_FINAL;
      ST_MAIN:  state_d = ST_SBOX;
      ST_FINAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  // Word groups are aligned to SBOX_WORDS, so the slice never leaves the state.
  assign grp_hi = 127 - GW * (int'(w_q) / SBOX_WORDS);

  always_comb begin
    block_d = block_q;
    round_d = round_q;
    nr_d    = nr_q;
    w_d     = w_q;
    ready_d = ready_q;
    sboxw   = '0;
    case (state_q)
      ST_IDLE: begin
        if (next && !abort) begin
          ready_d = 1'b0;
          round_d = '0;
          nr_d    = (keylen == 2'd1) ? 4'd12 : (keylen == 2'd2) ? 4'd14 : 4'd10;
        end
      end
      ST_INIT: begin
        block_d = block ^ round_key;
        round_d = 4'd1;
        w_d     = '0;
      end
      ST_SBOX: begin
        sboxw                 = block_q[grp_hi -: GW];
        block_d[grp_hi -: GW] = new_sboxw;
        w_d                   = w_q + WSTEP;
      end
      ST_MAIN: begin
        block_d = mix_columns(shift_rows(block_q)) ^ round_key;
        round_d = round_q + 4'd1;
        w_d     = '0;
      end
      ST_FINAL: begin
        block_d = shift_rows(block_q) ^ round_key;
        ready_d = 1'b1;
      end
      default: ;
    endcase
    // Cancel beats every datapath update, including the final round.
    if (abort && state_q != ST_IDLE) begin
      block_d = '0;
      round_d = '0;
      w_d     = '0;
      ready_d = 1'b1;
    end
  end

  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule
